digitron_scan_ctrl: RTL

Parametrised time-multiplexed 7-segment scan driver for the responder display. It serves NUM_DIGITS common-cathode digits, using active-high segments (bit7 = decimal point) and active-low digit selects. Beyond the fixed 3-digit scanner, it adds:
- per-digit enable, blink and decimal point
- a dead-time (anti-ghosting) window at the start of each slot
- leading-zero suppression
- a frame-start strobe

It sits between the timer/player-number logic and the board pins.

---
 rtl/digitron_pkg.sv | 32 +++
 rtl/digitron_seg_decode.sv | 27 ++
 rtl/digitron_scan_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/digitron_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan driver.
package digitron_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_DASH = 4'd10;

  // Digit selects are active low; every select parked at this level is "no digit".
  localparam logic CS_IDLE = 1'b1;

  typedef enum logic {
    PHASE_VISIBLE = 1'b0,
    PHASE_HIDDEN  = 1'b1
  } blink_phase_e;

  typedef struct packed {
    logic       dp;
    logic [6:0] seg;
  } seg_word_t;

endpackage

// File: rtl/digitron_seg_decode.sv
// Combinational BCD nibble to 7-segment pattern decoder (segments active high).
module digitron_seg_decode
  import digitron_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_c_o
);

  always_comb begin
    seg_c_o = SEG_BLANK;
    case (nib_i)
      4'd0:     seg_c_o = SEG_0;
      4'd1:     seg_c_o = SEG_1;
      4'd2:     seg_c_o = SEG_2;
      4'd3:     seg_c_o = SEG_3;
      4'd4:     seg_c_o = SEG_4;
      4'd5:     seg_c_o = SEG_5;
      4'd6:     seg_c_o = SEG_6;
      4'd7:     seg_c_o = SEG_7;
      4'd8:     seg_c_o = SEG_8;
      4'd9:     seg_c_o = SEG_9;
      BCD_DASH: seg_c_o = SEG_DASH;
      default:  seg_c_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/digitron_scan_ctrl.sv
// Time-multiplexed common-cathode display scanner with per-digit enable, blink,
// decimal point, anti-ghosting dead time and leading-zero suppression.
module digitron_scan_ctrl
  import digitron_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_TICKS   = 50000,
  parameter int unsigned BLANK_TICKS  = 500,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic [4*NUM_DIGITS-1:0] Digit_Data,
  input  logic [NUM_DIGITS-1:0]   Digit_Enable,
  input  logic [NUM_DIGITS-1:0]   Blink_Mask,
  input  logic [NUM_DIGITS-1:0]   DP_Mask,
  input  logic                    Lz_Suppress,
  output logic [7:0]              Digitron_Out,
  output logic [NUM_DIGITS-1:0]   DigitronCS_Out,
  output logic                    Frame_Start
);

  localparam int unsigned TICK_W = $clog2(SCAN_TICKS);
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRM_W-1:0]      frm_q, frm_d;
  blink_phase_e          phase_q, phase_d;
  seg_word_t             seg_q, seg_d;
  logic [NUM_DIGITS-1:0] cs_q, cs_d;
  logic                  fs_q, fs_d;

  logic [NUM_DIGITS-1:0] zero_or_off;
  logic [NUM_DIGITS-1:0] lz_supp;
  logic                  in_blank;

  // Digit i is a leading zero when it and every enabled digit above it read 0.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
    assign zero_or_off[gi] = (Digit_Data[4*gi +: 4] == 4'd0) | ~Digit_Enable[gi];
    if (gi == 0) begin : g_lsd
      assign lz_supp[gi] = 1'b0;
    end else if (gi == NUM_DIGITS - 1) begin : g_msd
      assign lz_supp[gi] = Lz_Suppress & (Digit_Data[4*gi +: 4] == 4'd0);
    end else begin : g_mid
      assign lz_supp[gi] = Lz_Suppress & (Digit_Data[4*gi +: 4] == 4'd0)
                         & (&zero_or_off[NUM_DIGITS-1:gi+1]);
    end
  end

  if (BLANK_TICKS == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (tick_q < TICK_W'(BLANK_TICKS));
  end

  logic [3:0] nib_sel;
  logic       en_sel, blink_sel, dp_sel, supp_sel;
  logic [6:0] seg_c;

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    nib_sel   = 4'd0;
    en_sel    = 1'b0;
    blink_sel = 1'b0;
    dp_sel    = 1'b0;
    supp_sel  = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel   = Digit_Data[4*i +: 4];
        en_sel    = Digit_Enable[i];
        blink_sel = Blink_Mask[i];
        dp_sel    = DP_Mask[i];
        supp_sel  = lz_supp[i];
      end
    end
  end

  digitron_seg_decode u_decode (
    .nib_i   (nib_sel),
    .seg_c_o (seg_c)
  );

  logic dark;

  always_comb begin
    tick_d  = tick_q + TICK_W'(1);
    idx_d   = idx_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    seg_d   = '0;
    cs_d    = {NUM_DIGITS{CS_IDLE}};
    fs_d    = (tick_q == '0) && (idx_q == '0);

    // Slot wrap advances the digit; a digit wrap ends the frame and may flip blink.
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        if (frm_q == FRM_LAST) begin
          frm_d   = '0;
          phase_d = (phase_q == PHASE_VISIBLE) ? PHASE_HIDDEN : PHASE_VISIBLE;
        end else begin
          frm_d = frm_q + FRM_W'(1);
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    dark = in_blank | ~en_sel | (blink_sel & (phase_q == PHASE_HIDDEN)) | supp_sel;
    if (!dark) begin
      seg_d.dp  = dp_sel;
      seg_d.seg = seg_c;
      cs_d      = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      tick_q  <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= PHASE_VISIBLE;
      seg_q   <= '0;
      cs_q    <= {NUM_DIGITS{CS_IDLE}};
      fs_q    <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      cs_q    <= cs_d;
      fs_q    <= fs_d;
    end
  end

  assign Digitron_Out   = seg_q;
  assign DigitronCS_Out = cs_q;
  assign Frame_Start    = fs_q;

endmodule
